vic_wb_ctrl: RTL and testbench
==============================

Name: vic_wb_ctrl

Overview:
Writeback scheduler placed downstream of the victim cache. Captures up to two fired victims per cycle into an in-order writeback buffer. Drains the buffer to memory as BUS_STORE commands over the single memory port, which it shares with the data-cache load requester. Loads have priority unless buffer occupancy reaches a high-water mark.

Parameters:
DEPTH, 8, writeback buffer entries; power of 2, at least 4
HIGH_WATER, 6, occupancy at or above which stores take priority over loads

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fired_valid1  in  1  victim 1 present
fired_valid2  in  1  victim 2 present
fired_tag1  in  `NUM_TAG_BITS  victim 1 tag
fired_tag2  in  `NUM_TAG_BITS  victim 2 tag
fired_set1  in  `NUM_SET_BITS  victim 1 set index
fired_set2  in  `NUM_SET_BITS  victim 2 set index
fired_data1  in  64  victim 1 line data
fired_data2  in  64  victim 2 line data
wb_ready  out  1  at least 2 free entries (registered count)
ld_req  in  1  load requester wants memory port
ld_addr  in  64  load address
ld_grant  out  1  load driven onto port this cycle
mem2proc_response  in  4  nonzero = command accepted
proc2mem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
proc2mem_addr  out  64  address
proc2mem_data  out  64  store data
wb_count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: push dropped
fwd_valid  in  1  forwarding lookup valid
fwd_addr  in  64  forwarding lookup address
fwd_hit  out  1  lookup matched a pending entry
fwd_data  out  64  data of matching entry

Behaviour:
- Entry contents: {tag, set, data}. Address = zero-extend({tag, set, 3'b000}) to 64 bits.
- Push:
  - Victim 1 is enqueued before victim 2; up to 2 pushes per cycle.
  - Tail pointer advances by the number pushed, modulo DEPTH.
  - Space is checked against the registered count only; a same-cycle pop gives no credit.
  - If a push arrives with insufficient space, entries that fit are taken in order (victim 1 first), the rest are dropped, and overflow is set and held until reset.
- wb_ready = (DEPTH - wb_count) >= 2, computed from registered state.
- FSM states:
  - IDLE: buffer empty.
  - DRAIN: buffer nonempty, count < HIGH_WATER; loads win arbitration.
  - FORCE: count >= HIGH_WATER; stores win arbitration.
  - Transitions are evaluated on the next-cycle count: 0 → IDLE; 1..HIGH_WATER-1 → DRAIN; ≥ HIGH_WATER → FORCE.
- Arbitration (combinational, each cycle):
  - IDLE: ld_req → BUS_LOAD with ld_addr, ld_grant=1. Otherwise BUS_NONE.
  - DRAIN: ld_req → load as above. Otherwise BUS_STORE with the head entry's addr/data.
  - FORCE: BUS_STORE with the head entry; ld_grant=0 regardless of ld_req.
- Pop: the head pops at the clock edge only when BUS_STORE is driven and mem2proc_response != 0. If the response is 0, the same store is re-driven next cycle; the head is unchanged.
- ld_grant means the load is driven; the load requester owns its own response check.
- Simultaneous pop and 2 pushes: count_next = count + pushes - pop, and pointers wrap independently.
- Reset:
  - Pointers and count = 0; state = IDLE; overflow = 0.
  - proc2mem_command = BUS_NONE, addr/data = 0, ld_grant = 0, wb_ready = 1.
  - Reset mid-drain discards all entries; no partial store is replayed.
- Latency: a victim pushed at edge N can be driven as a store in cycle N+1 at the earliest.

Optional Feature:
VIC_WB_FWD_EN
- Defined:
  - fwd_addr (bits 63:3) is compared against every valid entry; fwd_hit is combinational in the same cycle.
  - On multiple matches, the youngest entry (closest to tail) supplies fwd_data.
  - An entry popping this cycle still matches.
  - Pushes in the current cycle are not visible to the lookup.
- Undefined: fwd_hit = 0 and fwd_data = 0; ports remain present; no compare logic is built.

Test Plan:
- Reset, then push tag=0x12/set=0x3 and tag=0x20/set=0x1 in one cycle, response=1, no ld_req → stores to the addresses for {0x12,0x3} then {0x20,0x1} on consecutive cycles; wb_count goes 2,1,0.
- Buffer holds 2 entries, ld_req=1 for 3 cycles → ld_grant=1 and BUS_LOAD for 3 cycles; stores resume when ld_req drops.
- Fill to 6 entries with ld_req held at 1 → state FORCE, ld_grant=0, BUS_STORE issued until count=5, then loads regain the port.
- Response=0 for 4 cycles with head at addr 0x1A8 → same store re-driven 4 cycles, wb_count constant, pops on first nonzero response.
- Count=7 with a dual push → only victim 1 enqueued, count=8, overflow=1 sticky, wb_ready=0.
- VIC_WB_FWD_EN defined: two pending entries at the same address with data 0xAA then 0xBB, lookup that address → fwd_hit=1, fwd_data=0xBB. Undefined: fwd_hit=0.

Source files
------------

// File: rtl/vic_wb_ctrl.sv
// vic_wb_ctrl: in-order victim writeback buffer that shares the memory port with data-cache loads.
// Optional store-to-load forwarding lookup is built only when VIC_WB_FWD_EN is defined.
`ifndef NUM_TAG_BITS
`define NUM_TAG_BITS 13
`endif
`ifndef NUM_SET_BITS
`define NUM_SET_BITS 4
`endif

module vic_wb_ctrl #(
    parameter int DEPTH      = 8,
    parameter int HIGH_WATER = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     fired_valid1,
    input  logic                     fired_valid2,
    input  logic [`NUM_TAG_BITS-1:0] fired_tag1,
    input  logic [`NUM_TAG_BITS-1:0] fired_tag2,
    input  logic [`NUM_SET_BITS-1:0] fired_set1,
    input  logic [`NUM_SET_BITS-1:0] fired_set2,
    input  logic [63:0]              fired_data1,
    input  logic [63:0]              fired_data2,
    output logic                     wb_ready,
    input  logic                     ld_req,
    input  logic [63:0]              ld_addr,
    output logic                     ld_grant,
    input  logic [3:0]               mem2proc_response,
    output logic [1:0]               proc2mem_command,
    output logic [63:0]              proc2mem_addr,
    output logic [63:0]              proc2mem_data,
    output logic [$clog2(DEPTH):0]   wb_count,
    output logic                     overflow,
    input  logic                     fwd_valid,
    input  logic [63:0]              fwd_addr,
    output logic                     fwd_hit,
    output logic [63:0]              fwd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = `NUM_TAG_BITS;
    localparam int SW = `NUM_SET_BITS;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FORCE = 2'd2
    } state_t;

    function automatic logic [63:0] entry_addr(input logic [TW-1:0] tag, input logic [SW-1:0] set);
        entry_addr = 64'({tag, set, 3'b000});
    endfunction

    logic [TW-1:0] tag_q  [DEPTH];
    logic [SW-1:0] set_q  [DEPTH];
    logic [63:0]   data_q [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail2;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] free_cnt;
    logic [CW-1:0] push_cnt;
    logic [CW-1:0] count_next;
    logic          push1;
    logic          push2;
    logic          pop;
    logic          drop;

    // Space comes only from the registered count, so a pop in this cycle never makes room.
    assign free_cnt   = CW'(DEPTH) - wb_count;
    assign push1      = fired_valid1 && (free_cnt != '0);
    assign push2      = fired_valid2 && (free_cnt >= (push1 ? CW'(2) : CW'(1)));
    assign drop       = (fired_valid1 && !push1) || (fired_valid2 && !push2);
    assign push_cnt   = CW'(push1) + CW'(push2);
    assign tail2      = push1 ? (tail + PW'(1)) : tail;
    assign pop        = (proc2mem_command == BUS_STORE) && (mem2proc_response != 4'd0);
    assign count_next = wb_count + push_cnt - CW'(pop);
    assign wb_ready   = (free_cnt >= CW'(2));

    // Next state follows the occupancy the buffer will have after this edge.
    always_comb begin
        if (count_next == '0) begin
            state_next = IDLE;
        end else if (count_next >= CW'(HIGH_WATER)) begin
            state_next = FORCE;
        end else begin
            state_next = DRAIN;
        end
    end

    // Control state: pointers, occupancy, scheduler state and sticky overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            wb_count <= '0;
            state    <= IDLE;
            overflow <= 1'b0;
        end else begin
            head     <= pop ? (head + PW'(1)) : head;
            tail     <= tail + PW'(push_cnt);
            wb_count <= count_next;
            state    <= state_next;
            overflow <= overflow | drop;
        end
    end

    // Entry storage; contents beyond the occupancy are don't-care so no reset is needed.
    always_ff @(posedge clock) begin
        if (push1) begin
            tag_q[tail]  <= fired_tag1;
            set_q[tail]  <= fired_set1;
            data_q[tail] <= fired_data1;
        end
        if (push2) begin
            tag_q[tail2]  <= fired_tag2;
            set_q[tail2]  <= fired_set2;
            data_q[tail2] <= fired_data2;
        end
    end

    // Port arbitration: loads win in IDLE/DRAIN, the head store owns the port in FORCE.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = 64'd0;
        proc2mem_data    = 64'd0;
        ld_grant         = 1'b0;
        if (reset) begin
            proc2mem_command = BUS_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        proc2mem_command = BUS_LOAD;
                        proc2mem_addr    = ld_addr;
                        ld_grant         = 1'b1;
                    end else begin
                        proc2mem_command = BUS_NONE;
                    end
                end
                DRAIN: begin
                    if (ld_req) begin
                        proc2mem_command = BUS_LOAD;
                        proc2mem_addr    = ld_addr;
                        ld_grant         = 1'b1;
                    end else begin
                        proc2mem_command = BUS_STORE;
                        proc2mem_addr    = entry_addr(tag_q[head], set_q[head]);
                        proc2mem_data    = data_q[head];
                    end
                end
                FORCE: begin
                    proc2mem_command = BUS_STORE;
                    proc2mem_addr    = entry_addr(tag_q[head], set_q[head]);
                    proc2mem_data    = data_q[head];
                end
                default: begin
                    proc2mem_command = BUS_NONE;
                end
            endcase
        end
    end

`ifdef VIC_WB_FWD_EN
    logic [PW-1:0] fwd_idx;
    logic          fwd_match;

    // Walk entries oldest to youngest so the youngest match supplies the data.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_data  = 64'd0;
        fwd_idx   = '0;
        fwd_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx   = head + PW'(i);
            fwd_match = fwd_valid && (CW'(i) < wb_count) &&
                        (entry_addr(tag_q[fwd_idx], set_q[fwd_idx]) == {fwd_addr[63:3], 3'b000});
            fwd_hit   = fwd_hit | fwd_match;
            fwd_data  = fwd_match ? data_q[fwd_idx] : fwd_data;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{fwd_valid, fwd_addr};
    assign fwd_hit    = 1'b0;
    assign fwd_data   = 64'd0;
`endif

endmodule

// File: tb/tb_vic_wb_ctrl.sv
// Directed bench for vic_wb_ctrl: stimulus queues expected bus transactions,
// a monitor compares every driven command against the queue head.
`ifndef NUM_TAG_BITS
`define NUM_TAG_BITS 13
`endif
`ifndef NUM_SET_BITS
`define NUM_SET_BITS 4
`endif

module tb_vic_wb_ctrl;
    localparam int TW = `NUM_TAG_BITS;
    localparam int SW = `NUM_SET_BITS;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
`ifdef VIC_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          fired_valid1, fired_valid2;
    logic [TW-1:0] fired_tag1, fired_tag2;
    logic [SW-1:0] fired_set1, fired_set2;
    logic [63:0]   fired_data1, fired_data2;
    logic          wb_ready;
    logic          ld_req;
    logic [63:0]   ld_addr;
    logic          ld_grant;
    logic [3:0]    mem2proc_response;
    logic [1:0]    proc2mem_command;
    logic [63:0]   proc2mem_addr;
    logic [63:0]   proc2mem_data;
    logic [3:0]    wb_count;
    logic          overflow;
    logic          fwd_valid;
    logic [63:0]   fwd_addr;
    logic          fwd_hit;
    logic [63:0]   fwd_data;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    vic_wb_ctrl #(.DEPTH(8), .HIGH_WATER(6)) dut (
        .clock(clock), .reset(reset),
        .fired_valid1(fired_valid1), .fired_valid2(fired_valid2),
        .fired_tag1(fired_tag1), .fired_tag2(fired_tag2),
        .fired_set1(fired_set1), .fired_set2(fired_set2),
        .fired_data1(fired_data1), .fired_data2(fired_data2),
        .wb_ready(wb_ready), .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant),
        .mem2proc_response(mem2proc_response), .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .wb_count(wb_count), .overflow(overflow),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] addr_of(input int tag, input int set);
        addr_of = (64'(tag) << (SW + 3)) | (64'(set) << 3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_bus(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data);
        exp_t e;
        e.cmd  = cmd;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic victims(input logic v1, input int t1, input int s1, input logic [63:0] d1,
                           input logic v2, input int t2, input int s2, input logic [63:0] d2);
        fired_valid1 = v1; fired_tag1 = TW'(t1); fired_set1 = SW'(s1); fired_data1 = d1;
        fired_valid2 = v2; fired_tag2 = TW'(t2); fired_set2 = SW'(s2); fired_data2 = d2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every cycle the port is in use must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (proc2mem_command !== BUS_NONE || ld_grant !== 1'b0) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_unexpected: got cmd=%0d addr=%h grant=%0b, expected idle port",
                             proc2mem_command, proc2mem_addr, ld_grant);
                end else begin
                    e = exp_q.pop_front();
                    if (proc2mem_command !== e.cmd || proc2mem_addr !== e.addr ||
                        ld_grant !== (e.cmd == BUS_LOAD) ||
                        (e.cmd == BUS_STORE && proc2mem_data !== e.data)) begin
                        n_fail++;
                        $display("FAIL bus_out: got cmd=%0d addr=%h data=%h grant=%0b, expected cmd=%0d addr=%h data=%h",
                                 proc2mem_command, proc2mem_addr, proc2mem_data, ld_grant, e.cmd, e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        ld_req = 1'b0; ld_addr = 64'd0; mem2proc_response = 4'd1;
        fwd_valid = 1'b0; fwd_addr = 64'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        chk("reset_grant", 64'(ld_grant), 64'd0);
        reset = 1'b0;
        #1;
        chk("reset_count", 64'(wb_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_ready", 64'(wb_ready), 64'd1);

        // Dual push then drain in order: count 2,1,0.
        victims(1'b1, 'h12, 'h3, 64'h1111, 1'b1, 'h20, 'h1, 64'h2222);
        expect_bus(BUS_STORE, 64'h918, 64'h1111);
        expect_bus(BUS_STORE, 64'h1008, 64'h2222);
        tick();
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        #1 chk("t1_count2", 64'(wb_count), 64'd2);
        tick();
        chk("t1_count1", 64'(wb_count), 64'd1);
        tick();
        chk("t1_count0", 64'(wb_count), 64'd0);

        // Loads win while occupancy is below the high-water mark.
        victims(1'b1, 'h01, 'h2, 64'hA1, 1'b1, 'h02, 'h4, 64'hA2);
        tick();
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        ld_req = 1'b1; ld_addr = 64'h8000_0040;
        for (int i = 0; i < 3; i++) begin
            expect_bus(BUS_LOAD, 64'h8000_0040, 64'd0);
            #1 chk("t2_grant", 64'(ld_grant), 64'd1);
            tick();
        end
        ld_req = 1'b0;
        #1 chk("t2_count_held", 64'(wb_count), 64'd2);
        expect_bus(BUS_STORE, 64'h90, 64'hA1);
        expect_bus(BUS_STORE, 64'h120, 64'hA2);
        tick();
        tick();
        chk("t2_count0", 64'(wb_count), 64'd0);

        // Reaching six entries forces a store despite a pending load.
        ld_req = 1'b1; ld_addr = 64'h9000;
        for (int p = 0; p < 3; p++) begin
            victims(1'b1, 'h30 + 2 * p, 0, 64'h300 + 64'(2 * p),
                    1'b1, 'h31 + 2 * p, 0, 64'h301 + 64'(2 * p));
            expect_bus(BUS_LOAD, 64'h9000, 64'd0);
            tick();
        end
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        expect_bus(BUS_STORE, 64'h1800, 64'h300);
        #1 chk("t3_count6", 64'(wb_count), 64'd6);
        chk("t3_force_nogrant", 64'(ld_grant), 64'd0);
        chk("t3_ready_at6", 64'(wb_ready), 64'd1);
        tick();
        expect_bus(BUS_LOAD, 64'h9000, 64'd0);
        #1 chk("t3_count5", 64'(wb_count), 64'd5);
        chk("t3_load_regains", 64'(ld_grant), 64'd1);
        tick();
        ld_req = 1'b0;
        for (int i = 1; i < 6; i++) expect_bus(BUS_STORE, 64'h1800 + 64'(i) * 64'h80, 64'h300 + 64'(i));
        repeat (5) tick();
        chk("t3_count0", 64'(wb_count), 64'd0);

        // Zero response keeps re-driving the head store without popping.
        mem2proc_response = 4'd0;
        victims(1'b1, 'h3, 'h5, 64'hDEAD_BEEF, 1'b0, 0, 0, 64'd0);
        tick();
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            expect_bus(BUS_STORE, 64'h1A8, 64'hDEAD_BEEF);
            #1 chk("t4_count_held", 64'(wb_count), 64'd1);
            tick();
        end
        mem2proc_response = 4'd1;
        expect_bus(BUS_STORE, 64'h1A8, 64'hDEAD_BEEF);
        tick();
        chk("t4_count0", 64'(wb_count), 64'd0);

        // Fill to seven with stalled memory, then a dual push overflows by one.
        mem2proc_response = 4'd0;
        victims(1'b1, 'h40, 7, 64'hC0DE_0000, 1'b1, 'h41, 7, 64'hC0DE_0001);
        tick();
        victims(1'b1, 'h42, 7, 64'hC0DE_0002, 1'b1, 'h43, 7, 64'hC0DE_0003);
        expect_bus(BUS_STORE, addr_of('h40, 7), 64'hC0DE_0000);
        tick();
        victims(1'b1, 'h44, 7, 64'hC0DE_0004, 1'b1, 'h45, 7, 64'hC0DE_0005);
        expect_bus(BUS_STORE, addr_of('h40, 7), 64'hC0DE_0000);
        tick();
        victims(1'b1, 'h46, 7, 64'hC0DE_0006, 1'b0, 0, 0, 64'd0);
        expect_bus(BUS_STORE, addr_of('h40, 7), 64'hC0DE_0000);
        tick();
        #1 chk("t5_count7", 64'(wb_count), 64'd7);
        chk("t5_ready_at7", 64'(wb_ready), 64'd0);
        chk("t5_no_overflow_yet", 64'(overflow), 64'd0);
        victims(1'b1, 'h47, 7, 64'hC0DE_0007, 1'b1, 'h7F, 7, 64'hBAD);
        expect_bus(BUS_STORE, addr_of('h40, 7), 64'hC0DE_0000);
        tick();
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        expect_bus(BUS_STORE, addr_of('h40, 7), 64'hC0DE_0000);
        #1 chk("t5_count8", 64'(wb_count), 64'd8);
        chk("t5_overflow", 64'(overflow), 64'd1);
        chk("t5_ready_full", 64'(wb_ready), 64'd0);
        tick();
        mem2proc_response = 4'd1;
        for (int i = 0; i < 8; i++) expect_bus(BUS_STORE, addr_of('h40 + i, 7), 64'hC0DE_0000 + 64'(i));
        repeat (8) tick();
        chk("t5_count0", 64'(wb_count), 64'd0);
        chk("t5_overflow_sticky", 64'(overflow), 64'd1);
        chk("t5_ready_empty", 64'(wb_ready), 64'd1);

        // Reset mid-drain discards pending stores and clears overflow.
        mem2proc_response = 4'd0;
        victims(1'b1, 'h50, 0, 64'h50, 1'b1, 'h51, 0, 64'h51);
        tick();
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        reset = 1'b1;
        #1 chk("rst_mid_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
        tick();
        reset = 1'b0;
        mem2proc_response = 4'd1;
        #1 chk("rst_mid_count", 64'(wb_count), 64'd0);
        chk("rst_mid_overflow", 64'(overflow), 64'd0);
        chk("rst_mid_ready", 64'(wb_ready), 64'd1);
        repeat (3) tick();

        // Forwarding lookup: youngest match wins, same-cycle pushes invisible.
        mem2proc_response = 4'd0;
        victims(1'b1, 'h66, 'h9, 64'hAA, 1'b1, 'h66, 'h9, 64'hBB);
        fwd_valid = 1'b1; fwd_addr = 64'h334D;
        #1 chk("fwd_push_invisible", 64'(fwd_hit), 64'd0);
        tick();
        victims(1'b0, 0, 0, 64'd0, 1'b0, 0, 0, 64'd0);
        expect_bus(BUS_STORE, 64'h3348, 64'hAA);
        #1 chk("fwd_hit", 64'(fwd_hit), 64'(FWD));
        chk("fwd_youngest", fwd_data, FWD ? 64'hBB : 64'd0);
        fwd_addr = 64'h3350;
        #1 chk("fwd_miss", 64'(fwd_hit), 64'd0);
        fwd_addr = 64'h334D;
        tick();
        mem2proc_response = 4'd1;
        expect_bus(BUS_STORE, 64'h3348, 64'hAA);
        expect_bus(BUS_STORE, 64'h3348, 64'hBB);
        tick();
        chk("fwd_popping_hit", 64'(fwd_hit), 64'(FWD));
        chk("fwd_popping_data", fwd_data, FWD ? 64'hBB : 64'd0);
        tick();
        chk("fwd_empty", 64'(fwd_hit), 64'd0);
        fwd_valid = 1'b0;
        repeat (2) tick();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bus_pending: got %0d unseen transactions, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
